// File: rtl/uart_wishbone_pkg.sv
// Shared constants and state encodings for the UART-to-Wishbone debug bridge.
`timescale 1ns/1ps
package uart_wishbone_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_ADDR,
    ST_WDATA,
    ST_WB_WRITE,
    ST_WB_READ,
    ST_TX_WORD
  } parser_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_START,
    PH_DATA,
    PH_STOP
  } bit_phase_e;

endpackage

// File: rtl/uart_bridge_phy.sv
// UART byte PHY: synchronised mid-bit RX sampler and TX shifter, 8N1, CLK_DIV clocks per bit.
`timescale 1ns/1ps
module uart_bridge_phy
  import uart_wishbone_pkg::*;
#(
  parameter int CLK_DIV = 217
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  bit_phase_e    rx_phase_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q, rx_data_q;
  logic          rx_valid_q, frame_err_q;

  bit_phase_e    tx_phase_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic          tx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_phase_q  <= PH_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= uart_rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (rx_phase_q)
        PH_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_phase_q <= PH_START;
            rx_cnt_q   <= '0;
          end
        end
        PH_START: begin
          // A start bit that is high again at its midpoint was only a glitch.
          if (rx_cnt_q == HALF) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_phase_q <= rx_sync_q ? PH_IDLE : PH_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        PH_DATA: begin
          if (rx_cnt_q == LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7) rx_phase_q <= PH_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        PH_STOP: begin
          if (rx_cnt_q == LAST) begin
            rx_cnt_q   <= '0;
            rx_phase_q <= PH_IDLE;
            if (rx_sync_q) begin
              rx_data_q  <= rx_shift_q;
              rx_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_phase_q <= PH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_phase_q <= PH_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (tx_phase_q)
        PH_IDLE: begin
          if (tx_valid) begin
            tx_shift_q <= tx_data;
            tx_q       <= 1'b0;
            tx_cnt_q   <= '0;
            tx_phase_q <= PH_START;
          end
        end
        PH_START: begin
          if (tx_cnt_q == LAST) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_phase_q <= PH_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        PH_DATA: begin
          if (tx_cnt_q == LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_phase_q <= PH_STOP;
            end else begin
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_bit_q   <= tx_bit_q + 1'b1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        PH_STOP: begin
          if (tx_cnt_q == LAST) begin
            tx_cnt_q   <= '0;
            tx_phase_q <= PH_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_phase_q <= PH_IDLE;
      endcase
    end
  end

  assign uart_tx   = tx_q;
  assign tx_ready  = (tx_phase_q == PH_IDLE);
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: rtl/uart_wishbone_bridge.sv
// Host debug bridge: parses UART command frames into single 32-bit Wishbone
// master cycles and streams read data back MSB byte first.
`timescale 1ns/1ps
module uart_wishbone_bridge
  import uart_wishbone_pkg::*;
#(
  parameter int CLK_DIV        = 217,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int ADDR_WIDTH     = 30
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  uart_rx,
  output logic                  uart_tx,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_we,
  output logic [ADDR_WIDTH-1:0] wb_adr,
  output logic [31:0]           wb_dat_w,
  output logic [3:0]            wb_sel,
  input  logic [31:0]           wb_dat_r,
  input  logic                  wb_ack,
  input  logic                  wb_err,
  output logic                  busy,
  output logic                  frame_err
);

  logic [7:0] rx_data;
  logic       rx_valid, tx_ready;

  parser_state_e         state_q;
  logic                  is_read_q;
  logic [7:0]            len_q;
  logic [1:0]            byte_cnt_q;
  logic [23:0]           addr_shift_q, wdata_q;
  logic [31:0]           rdata_q;
  logic                  wb_cyc_q, wb_stb_q, wb_we_q;
  logic [ADDR_WIDTH-1:0] wb_adr_q;
  logic [31:0]           wb_dat_w_q;
  logic [3:0]            wb_sel_q;
  logic [7:0]            tx_data_q;
  logic                  tx_valid_q;
  logic [31:0]           timer_q, timer_d;
  logic                  in_rx_state, timeout_hit;

  uart_bridge_phy #(.CLK_DIV(CLK_DIV)) u_phy (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .uart_tx   (uart_tx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .tx_data   (tx_data_q),
    .tx_valid  (tx_valid_q),
    .tx_ready  (tx_ready)
  );

  // Bus and TX progress only happen outside the byte-receiving states, so
  // holding the timer at zero there covers those restart events.
  assign in_rx_state = state_q inside {ST_LEN, ST_ADDR, ST_WDATA};
  assign timer_d     = timer_q + 32'd1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_rx_state && !rx_valid &&
                       (timer_d == 32'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      is_read_q    <= 1'b0;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      addr_shift_q <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      wb_cyc_q     <= 1'b0;
      wb_stb_q     <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_adr_q     <= '0;
      wb_dat_w_q   <= '0;
      wb_sel_q     <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      timer_q      <= '0;
    end else begin
      timer_q <= (rx_valid || !in_rx_state) ? '0 : timer_d;
      if (timeout_hit) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
              is_read_q <= (rx_data == CMD_READ);
              state_q   <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (rx_valid) begin
              len_q      <= rx_data;
              byte_cnt_q <= '0;
              state_q    <= ST_ADDR;
            end
          end
          ST_ADDR: begin
            if (rx_valid) begin
              addr_shift_q <= {addr_shift_q[15:0], rx_data};
              byte_cnt_q   <= byte_cnt_q + 1'b1;
              if (byte_cnt_q == 2'd3) begin
                wb_adr_q <= ADDR_WIDTH'({addr_shift_q, rx_data});
                if (len_q == 8'd0) begin
                  state_q <= ST_IDLE;
                end else if (is_read_q) begin
                  wb_cyc_q <= 1'b1;
                  wb_stb_q <= 1'b1;
                  wb_we_q  <= 1'b0;
                  wb_sel_q <= 4'hF;
                  state_q  <= ST_WB_READ;
                end else begin
                  state_q <= ST_WDATA;
                end
              end
            end
          end
          ST_WDATA: begin
            if (rx_valid) begin
              wdata_q    <= {wdata_q[15:0], rx_data};
              byte_cnt_q <= byte_cnt_q + 1'b1;
              if (byte_cnt_q == 2'd3) begin
                wb_dat_w_q <= {wdata_q, rx_data};
                wb_cyc_q   <= 1'b1;
                wb_stb_q   <= 1'b1;
                wb_we_q    <= 1'b1;
                wb_sel_q   <= 4'hF;
                state_q    <= ST_WB_WRITE;
              end
            end
          end
          ST_WB_WRITE: begin
            if (wb_ack || wb_err) begin
              wb_cyc_q <= 1'b0;
              wb_stb_q <= 1'b0;
              wb_we_q  <= 1'b0;
              wb_sel_q <= '0;
              wb_adr_q <= wb_adr_q + 1'b1;
              len_q    <= len_q - 1'b1;
              state_q  <= (len_q == 8'd1) ? ST_IDLE : ST_WDATA;
            end
          end
          ST_WB_READ: begin
            if (wb_ack || wb_err) begin
              wb_cyc_q   <= 1'b0;
              wb_stb_q   <= 1'b0;
              wb_sel_q   <= '0;
              rdata_q    <= wb_err ? 32'h0 : wb_dat_r;
              wb_adr_q   <= wb_adr_q + 1'b1;
              len_q      <= len_q - 1'b1;
              byte_cnt_q <= '0;
              state_q    <= ST_TX_WORD;
            end
          end
          ST_TX_WORD: begin
            // tx_valid_q drops on the handshake edge; the PHY is then busy,
            // so the next byte is only offered once the line frees up.
            if (tx_valid_q) begin
              if (tx_ready) begin
                tx_valid_q <= 1'b0;
                byte_cnt_q <= byte_cnt_q + 1'b1;
                if (byte_cnt_q == 2'd3) begin
                  if (len_q == 8'd0) begin
                    state_q <= ST_IDLE;
                  end else begin
                    wb_cyc_q <= 1'b1;
                    wb_stb_q <= 1'b1;
                    wb_we_q  <= 1'b0;
                    wb_sel_q <= 4'hF;
                    state_q  <= ST_WB_READ;
                  end
                end
              end
            end else if (tx_ready) begin
              tx_data_q  <= rdata_q[31:24];
              rdata_q    <= {rdata_q[23:0], 8'h00};
              tx_valid_q <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign wb_cyc   = wb_cyc_q;
  assign wb_stb   = wb_stb_q;
  assign wb_we    = wb_we_q;
  assign wb_adr   = wb_adr_q;
  assign wb_dat_w = wb_dat_w_q;
  assign wb_sel   = wb_sel_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_wishbone_bridge.sv
// Directed bench: table of command frames against a Wishbone slave model and
// a UART line decoder, plus frame-error, timeout and reset sequences.
`timescale 1ns/1ps
module tb_uart_wishbone_bridge;

  localparam int CLK_DIV = 16;
  localparam int TMO     = 1000;
  localparam int AW      = 30;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          uart_rx;
  logic          uart_tx;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_adr;
  logic [31:0]   wb_dat_w;
  logic [3:0]    wb_sel;
  logic [31:0]   wb_dat_r;
  logic          wb_ack, wb_err;
  logic          busy, frame_err;

  always #5 clk = ~clk;

  uart_wishbone_bridge #(.CLK_DIV(CLK_DIV), .TIMEOUT_CYCLES(TMO), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .uart_tx   (uart_tx),
    .wb_cyc    (wb_cyc),
    .wb_stb    (wb_stb),
    .wb_we     (wb_we),
    .wb_adr    (wb_adr),
    .wb_dat_w  (wb_dat_w),
    .wb_sel    (wb_sel),
    .wb_dat_r  (wb_dat_r),
    .wb_ack    (wb_ack),
    .wb_err    (wb_err),
    .busy      (busy),
    .frame_err (frame_err)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
  } wb_rec_t;

  typedef struct {
    logic [7:0] data;
    bit         ok;
  } tx_rec_t;

  typedef struct {
    logic [7:0]    cmd;
    logic [7:0]    len;
    logic [31:0]   addr;
    logic [31:0]   d0;
    logic [31:0]   d1;
    logic          s_err;
    int            exp_n;
    logic [AW-1:0] exp_adr0;
    logic [AW-1:0] exp_adr1;
    logic [31:0]   exp_w0;
    logic [31:0]   exp_w1;
  } vec_t;

  wb_rec_t     wb_q[$];
  tx_rec_t     tx_q[$];
  logic [31:0] mem [logic [AW-1:0]];
  logic        slave_err  = 1'b0;
  logic        slave_hang = 1'b0;
  int          fe_count   = 0;
  int          checks     = 0;
  int          errors     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wishbone slave: acks one cycle after seeing cyc&stb, logs every cycle.
  initial begin : wb_slave
    bit      acked;
    wb_rec_t r;
    acked    = 1'b0;
    wb_ack   = 1'b0;
    wb_err   = 1'b0;
    wb_dat_r = 32'h0;
    forever begin
      @(negedge clk);
      if (acked) begin
        wb_ack = 1'b0;
        wb_err = 1'b0;
        acked  = 1'b0;
      end else if (wb_cyc && wb_stb && !slave_hang) begin
        r.we = wb_we; r.adr = wb_adr; r.dat = wb_dat_w; r.sel = wb_sel;
        wb_q.push_back(r);
        if (wb_we) mem[wb_adr] = wb_dat_w;
        else wb_dat_r = mem.exists(wb_adr) ? mem[wb_adr] : 32'h0;
        if (slave_err) wb_err = 1'b1;
        else wb_ack = 1'b1;
        acked = 1'b1;
      end
    end
  end

  // UART line decoder: every bit must be flat for exactly CLK_DIV cycles.
  initial begin : tx_mon
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uart_tx === 1'b0) begin
        logic [9:0] bits;
        bit         ok;
        logic       first;
        tx_rec_t    r;
        bits = '0; ok = 1'b1; first = 1'b0;
        for (int k = 0; k < 10 * CLK_DIV; k++) begin
          if (k > 0) @(negedge clk);
          if (k % CLK_DIV == 0) first = uart_tx;
          else if (uart_tx !== first) ok = 1'b0;
          if (k % CLK_DIV == CLK_DIV / 2) bits[k / CLK_DIV] = uart_tx;
        end
        r.data = bits[8:1];
        r.ok   = ok && (bits[0] == 1'b0) && (bits[9] == 1'b1);
        tx_q.push_back(r);
      end
    end
  end

  initial begin : fe_mon
    forever begin
      @(negedge clk);
      if (frame_err === 1'b1) fe_count++;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CLK_DIV) @(negedge clk);
    uart_rx = 1'b1;
    if (!stop_bit) repeat (CLK_DIV) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [7:0] len, input logic [31:0] addr);
    send_byte(cmd, 1'b1);
    send_byte(len, 1'b1);
    send_word(addr);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy_idle"}, {31'b0, busy}, 32'h0);
  endtask

  task automatic wait_tx(input int n);
    int c;
    c = 0;
    while (tx_q.size() < n && c < n * 12 * CLK_DIV + 400) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic check_one_write(input string name, input logic [AW-1:0] adr, input logic [31:0] dat);
    check({name, "_count"}, wb_q.size(), 32'd1);
    if (wb_q.size() >= 1) begin
      check({name, "_we"}, {31'b0, wb_q[0].we}, 32'd1);
      check({name, "_adr"}, 32'(wb_q[0].adr), 32'(adr));
      check({name, "_dat"}, wb_q[0].dat, dat);
    end
  endtask

  vec_t vecs[10];

  initial begin
    logic [31:0]   ew;
    logic [AW-1:0] ea;
    logic [7:0]    eb;
    int            nw;

    vecs[0] = '{8'h02, 8'd1, 32'h0400_0000, 32'h0,         32'h0,         1'b0, 1, 30'h0400_0000, 30'h0,        32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{8'h01, 8'd1, 32'h0400_0000, 32'h1234_5678, 32'h0,         1'b0, 1, 30'h0400_0000, 30'h0,        32'h1234_5678, 32'h0};
    vecs[2] = '{8'h02, 8'd1, 32'h0400_0000, 32'h0,         32'h0,         1'b0, 1, 30'h0400_0000, 30'h0,        32'h1234_5678, 32'h0};
    vecs[3] = '{8'h01, 8'd2, 32'h0000_2400, 32'h0000_000E, 32'h0,         1'b0, 2, 30'h2400,      30'h2401,     32'h0000_000E, 32'h0};
    vecs[4] = '{8'h02, 8'd2, 32'h0000_2400, 32'h0,         32'h0,         1'b0, 2, 30'h2400,      30'h2401,     32'h0000_000E, 32'h0};
    vecs[5] = '{8'h02, 8'd1, 32'h0400_0000, 32'h0,         32'h0,         1'b1, 1, 30'h0400_0000, 30'h0,        32'h0,         32'h0};
    vecs[6] = '{8'h01, 8'd2, 32'hFFFF_FFFF, 32'hCAFE_F00D, 32'h0BAD_C0DE, 1'b0, 2, 30'h3FFF_FFFF, 30'h0,        32'hCAFE_F00D, 32'h0BAD_C0DE};
    vecs[7] = '{8'h02, 8'd2, 32'h7FFF_FFFF, 32'h0,         32'h0,         1'b0, 2, 30'h3FFF_FFFF, 30'h0,        32'hCAFE_F00D, 32'h0BAD_C0DE};
    vecs[8] = '{8'h01, 8'd0, 32'h0000_0100, 32'h0,         32'h0,         1'b0, 0, 30'h0,         30'h0,        32'h0,         32'h0};
    vecs[9] = '{8'h55, 8'd0, 32'h0,         32'h0,         32'h0,         1'b0, 0, 30'h0,         30'h0,        32'h0,         32'h0};

    mem[30'h0400_0000] = 32'hDEAD_BEEF;

    rst_n   = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_uart_tx",   {31'b0, uart_tx},   32'd1);
    check("rst_wb_cyc",    {31'b0, wb_cyc},    32'd0);
    check("rst_wb_stb",    {31'b0, wb_stb},    32'd0);
    check("rst_wb_we",     {31'b0, wb_we},     32'd0);
    check("rst_wb_adr",    32'(wb_adr),        32'd0);
    check("rst_wb_dat_w",  wb_dat_w,           32'd0);
    check("rst_wb_sel",    {28'b0, wb_sel},    32'd0);
    check("rst_busy",      {31'b0, busy},      32'd0);
    check("rst_frame_err", {31'b0, frame_err}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      wb_q.delete();
      tx_q.delete();
      slave_err = vecs[v].s_err;
      if (vecs[v].cmd == 8'h01 || vecs[v].cmd == 8'h02) begin
        send_hdr(vecs[v].cmd, vecs[v].len, vecs[v].addr);
        if (vecs[v].cmd == 8'h01)
          for (int w = 0; w < int'(vecs[v].len); w++) send_word(w == 0 ? vecs[v].d0 : vecs[v].d1);
      end else begin
        send_byte(vecs[v].cmd, 1'b1);
      end
      nw = (vecs[v].cmd == 8'h02) ? vecs[v].exp_n : 0;
      wait_tx(4 * nw);
      wait_idle($sformatf("v%0d", v));
      repeat (2 * CLK_DIV) @(negedge clk);
      slave_err = 1'b0;
      $display("vec %0d cmd=%h len=%0d addr=%h bus_cycles=%0d tx_bytes=%0d",
               v, vecs[v].cmd, vecs[v].len, vecs[v].addr, wb_q.size(), tx_q.size());

      check($sformatf("v%0d_bus_count", v), wb_q.size(), 32'(vecs[v].exp_n));
      check($sformatf("v%0d_tx_count", v), tx_q.size(), 32'(4 * nw));
      for (int i = 0; i < vecs[v].exp_n; i++) begin
        ea = (i == 0) ? vecs[v].exp_adr0 : vecs[v].exp_adr1;
        ew = (i == 0) ? vecs[v].exp_w0 : vecs[v].exp_w1;
        if (i < wb_q.size()) begin
          check($sformatf("v%0d_w%0d_we", v, i), {31'b0, wb_q[i].we}, {31'b0, vecs[v].cmd == 8'h01});
          check($sformatf("v%0d_w%0d_adr", v, i), 32'(wb_q[i].adr), 32'(ea));
          check($sformatf("v%0d_w%0d_sel", v, i), {28'b0, wb_q[i].sel}, 32'hF);
          if (vecs[v].cmd == 8'h01)
            check($sformatf("v%0d_w%0d_dat", v, i), wb_q[i].dat, ew);
        end
        if (vecs[v].cmd == 8'h02) begin
          for (int j = 0; j < 4; j++) begin
            eb = ew[31 - 8*j -: 8];
            if (4*i + j < tx_q.size()) begin
              check($sformatf("v%0d_tx%0d_byte", v, 4*i + j), {24'b0, tx_q[4*i + j].data}, {24'b0, eb});
              check($sformatf("v%0d_tx%0d_framing", v, 4*i + j), {31'b0, tx_q[4*i + j].ok}, 32'd1);
            end
          end
        end
      end
    end

    // Stop bit forced low on a byte that would otherwise open a write frame.
    fe_count = 0;
    wb_q.delete();
    send_byte(8'h01, 1'b0);
    repeat (4) @(negedge clk);
    $display("seq frame_err: pulses=%0d busy=%0d", fe_count, busy);
    check("fe_pulse_cycles", fe_count, 32'd1);
    check("fe_busy", {31'b0, busy}, 32'd0);
    check("fe_no_bus", wb_q.size(), 32'd0);

    // Abandon a frame after the first address byte.
    send_byte(8'h01, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h04, 1'b1);
    repeat (800) @(negedge clk);
    check("tmo_still_busy", {31'b0, busy}, 32'd1);
    repeat (250) @(negedge clk);
    check("tmo_back_idle", {31'b0, busy}, 32'd0);
    send_hdr(8'h01, 8'd1, 32'h0000_0030);
    send_word(32'hAABB_CCDD);
    wait_idle("tmo_next");
    $display("seq timeout: follow-up bus_cycles=%0d", wb_q.size());
    check_one_write("tmo_next", 30'h30, 32'hAABB_CCDD);

    // Reset while a TX byte is mid-flight (bit 2 of 0x12 is low).
    tx_q.delete();
    send_hdr(8'h02, 8'd1, 32'h0400_0000);
    for (int c = 0; c < 2000 && uart_tx !== 1'b0; c++) @(negedge clk);
    repeat (3 * CLK_DIV + CLK_DIV / 2) @(negedge clk);
    check("rst_tx_pre_low", {31'b0, uart_tx}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_tx_truncated", {31'b0, uart_tx}, 32'd1);
    check("rst_tx_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * CLK_DIV) @(negedge clk);
    tx_q.delete();
    $display("seq reset during tx: line released");

    // Reset while a write waits for an ack that never comes.
    slave_hang = 1'b1;
    wb_q.delete();
    send_hdr(8'h01, 8'd1, 32'h0000_0020);
    send_word(32'h1122_3344);
    for (int c = 0; c < 200 && wb_cyc !== 1'b1; c++) @(negedge clk);
    check("rst_cyc_pre", {31'b0, wb_cyc}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_cyc_dropped", {31'b0, wb_cyc}, 32'd0);
    check("rst_stb_dropped", {31'b0, wb_stb}, 32'd0);
    check("rst_uart_tx_high", {31'b0, uart_tx}, 32'd1);
    check("rst_busy_low", {31'b0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    slave_hang = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_no_ack_logged", wb_q.size(), 32'd0);
    send_hdr(8'h01, 8'd1, 32'h0000_0021);
    send_word(32'h5566_7788);
    wait_idle("rst_next");
    $display("seq reset during bus cycle: follow-up bus_cycles=%0d", wb_q.size());
    check_one_write("rst_next", 30'h21, 32'h5566_7788);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
